// File: rtl/ped_pkg.sv
// Shared state encoding and default service timing for the pedestrian signal controller.
package ped_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_WAIT  = 3'b001,
        S_WALK  = 3'b010,
        S_CLEAR = 3'b011,
        S_FAULT = 3'b100
    } ped_state_e;

    localparam int unsigned WALK_TIME_DEF  = 3;
    localparam int unsigned CLEAR_TIME_DEF = 2;

endpackage

// File: rtl/rise_detect.sv
// Registers a level input and flags the single cycle in which it goes 0 -> 1.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sig_d <= 1'b0;
        else          sig_d <= sig;
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian walk/don't-walk sequencer slaved to the vehicle lamps of an upstream traffic light.
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned WALK_TIME  = WALK_TIME_DEF,
    parameter int unsigned CLEAR_TIME = CLEAR_TIME_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       veh_red,
    input  logic       veh_yellow,
    input  logic       veh_green,
    input  logic       ped_button,
    output logic       walk,
    output logic       dont_walk,
    output logic       flash,
    output logic       req_pending,
    output logic [2:0] countdown,
    output logic       error
);

    // The whole walk + clearance window must sit inside the 6-cycle red phase.
    if (WALK_TIME < 1 || WALK_TIME > 4 || CLEAR_TIME < 1 || CLEAR_TIME > 4 ||
        WALK_TIME + CLEAR_TIME > 5) begin : g_bad_timing
        $error("ped_signal_ctrl: WALK_TIME/CLEAR_TIME out of range");
    end

    localparam logic [2:0] WALK_CNT  = 3'(WALK_TIME);
    localparam logic [2:0] CLEAR_CNT = 3'(CLEAR_TIME);

    ped_state_e state, state_nxt;
    logic [2:0] cnt_nxt;
    logic       flash_nxt, req_nxt;
    logic       red_rise, lamps_ok;

    rise_detect u_red_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (veh_red),
        .rise    (red_rise)
    );

    assign lamps_ok = $onehot({veh_red, veh_yellow, veh_green});

    always_comb begin
        state_nxt = state;
        cnt_nxt   = 3'd0;
        flash_nxt = 1'b0;
        req_nxt   = req_pending;
        unique case (state)
            S_IDLE: begin
                // A press coinciding with the red onset is served at once, never latched.
                if (ped_button && red_rise) begin
                    state_nxt = S_WALK;
                    cnt_nxt   = WALK_CNT;
                end else if (ped_button) begin
                    state_nxt = S_WAIT;
                    req_nxt   = 1'b1;
                end
            end
            S_WAIT: begin
                if (red_rise) begin
                    state_nxt = S_WALK;
                    cnt_nxt   = WALK_CNT;
                    req_nxt   = 1'b0;
                end
            end
            S_WALK: begin
                req_nxt = req_pending | ped_button;
                if (countdown == 3'd1) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = CLEAR_CNT;
                    flash_nxt = 1'b1;
                end else begin
                    cnt_nxt = countdown - 3'd1;
                end
            end
            S_CLEAR: begin
                req_nxt = req_pending | ped_button;
                if (countdown == 3'd1) begin
                    state_nxt = req_nxt ? S_WAIT : S_IDLE;
                end else begin
                    cnt_nxt   = countdown - 3'd1;
                    flash_nxt = ~flash;
                end
            end
            S_FAULT: begin
                flash_nxt = ~flash;
                req_nxt   = 1'b0;
            end
            default: state_nxt = S_FAULT;
        endcase

        // Lamp conflicts, or losing red while pedestrians are released, trump everything.
        if (state != S_FAULT &&
            (!lamps_ok || ((state == S_WALK || state == S_CLEAR) && !veh_red))) begin
            state_nxt = S_FAULT;
            cnt_nxt   = 3'd0;
            flash_nxt = 1'b1;
            req_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            countdown   <= 3'd0;
            flash       <= 1'b0;
            req_pending <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            countdown   <= cnt_nxt;
            flash       <= flash_nxt;
            req_pending <= req_nxt;
            error       <= (state_nxt == S_FAULT);
        end
    end

    assign walk      = (state == S_WALK);
    assign dont_walk = ~walk;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Vector table, multi-cycle corner sequences and a randomized traffic run against a timeline model.
module tb_ped_signal_ctrl;
    import ped_pkg::*;

    localparam int WT = 3;
    localparam int CT = 2;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] RG = 3'b101;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic veh_red = 1'b0, veh_yellow = 1'b0, veh_green = 1'b0, ped_button = 1'b0;
    logic walk, dont_walk, flash, req_pending, error;
    logic [2:0] countdown;
    logic [7:0] obs;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ped_signal_ctrl #(.WALK_TIME(WT), .CLEAR_TIME(CT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .veh_red     (veh_red),
        .veh_yellow  (veh_yellow),
        .veh_green   (veh_green),
        .ped_button  (ped_button),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .flash       (flash),
        .req_pending (req_pending),
        .countdown   (countdown),
        .error       (error)
    );

    assign obs = {walk, dont_walk, flash, req_pending, countdown, error};

    typedef struct {
        logic [2:0] lamps;
        logic       btn;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[25];

    // Observation word: {walk, dont_walk, flash, req_pending, countdown[2:0], error}
    function automatic logic [7:0] o(input logic w, input logic dw, input logic f,
                                     input logic rq, input int cd);
        return {w, dw, f, rq, 3'(cd), 1'b0};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] l, input logic b);
        {veh_red, veh_yellow, veh_green} = l;
        ped_button = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {veh_red, veh_yellow, veh_green} = G;
        ped_button = 1'b0;
        #1;
        check("reset_state", obs, o(0, 1, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Timeline model: a service starting at cycle s shows walk on s+1..s+WT and
    // clearance on s+WT+1..s+WT+CT; everything else is steady don't-walk.
    int  m_n;
    int  m_svc;
    bit  m_pend;
    bit  m_prev_red;

    task automatic model_step(input bit r, input bit b);
        bit rise;
        bit in_svc;
        rise   = r && !m_prev_red;
        in_svc = (m_svc >= 0) && (m_n >= m_svc + 1) && (m_n <= m_svc + WT + CT);
        if (!in_svc && rise && (m_pend || b)) begin
            m_svc  = m_n;
            m_pend = 1'b0;
        end else if (b) begin
            m_pend = 1'b1;
        end
        m_prev_red = r;
        m_n++;
    endtask

    function automatic logic [7:0] model_exp();
        int k;
        k = m_n - m_svc;
        if (m_svc >= 0 && k >= 1 && k <= WT)
            return o(1, 0, 0, m_pend, WT - k + 1);
        if (m_svc >= 0 && k > WT && k <= WT + CT)
            return o(0, 1, ((k - WT - 1) % 2) == 0, m_pend, WT + CT - k + 1);
        return o(0, 1, 0, m_pend, 0);
    endfunction

    initial begin
        logic [2:0] seq[$];
        logic       prev_flash;

        vecs[0]  = '{G, 1'b0, o(0, 1, 0, 0, 0)};
        vecs[1]  = '{G, 1'b1, o(0, 1, 0, 1, 0)};
        vecs[2]  = '{Y, 1'b0, o(0, 1, 0, 1, 0)};
        vecs[3]  = '{R, 1'b0, o(1, 0, 0, 0, 3)};
        vecs[4]  = '{R, 1'b0, o(1, 0, 0, 0, 2)};
        vecs[5]  = '{R, 1'b0, o(1, 0, 0, 0, 1)};
        vecs[6]  = '{R, 1'b0, o(0, 1, 1, 0, 2)};
        vecs[7]  = '{R, 1'b0, o(0, 1, 0, 0, 1)};
        vecs[8]  = '{R, 1'b0, o(0, 1, 0, 0, 0)};
        vecs[9]  = '{G, 1'b0, o(0, 1, 0, 0, 0)};
        vecs[10] = '{Y, 1'b0, o(0, 1, 0, 0, 0)};
        vecs[11] = '{R, 1'b1, o(1, 0, 0, 0, 3)};
        vecs[12] = '{R, 1'b0, o(1, 0, 0, 0, 2)};
        vecs[13] = '{R, 1'b1, o(1, 0, 0, 1, 1)};
        vecs[14] = '{R, 1'b0, o(0, 1, 1, 1, 2)};
        vecs[15] = '{R, 1'b0, o(0, 1, 0, 1, 1)};
        vecs[16] = '{R, 1'b0, o(0, 1, 0, 1, 0)};
        vecs[17] = '{G, 1'b0, o(0, 1, 0, 1, 0)};
        vecs[18] = '{Y, 1'b0, o(0, 1, 0, 1, 0)};
        vecs[19] = '{R, 1'b0, o(1, 0, 0, 0, 3)};
        vecs[20] = '{R, 1'b0, o(1, 0, 0, 0, 2)};
        vecs[21] = '{R, 1'b0, o(1, 0, 0, 0, 1)};
        vecs[22] = '{R, 1'b0, o(0, 1, 1, 0, 2)};
        vecs[23] = '{R, 1'b0, o(0, 1, 0, 0, 1)};
        vecs[24] = '{R, 1'b0, o(0, 1, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].lamps, vecs[i].btn);
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Green forced on mid-walk: fault is sticky and flash alternates.
        do_reset();
        drive(G, 1'b1);
        drive(R, 1'b0);
        drive(R, 1'b0);
        check("walk_cd2", obs, o(1, 0, 0, 0, 2));
        drive(RG, 1'b0);
        check("fault_entry", obs & 8'b1101_1111, 8'b0100_0001);
        prev_flash = flash;
        for (int i = 0; i < 4; i++) begin
            drive(R, 1'b1);
            check($sformatf("fault_hold%0d", i), obs & 8'b1101_1111, 8'b0100_0001);
            check($sformatf("fault_flash%0d", i), {7'b0, flash}, {7'b0, ~prev_flash});
            prev_flash = flash;
        end

        // Red lost during walk.
        do_reset();
        drive(G, 1'b1);
        drive(R, 1'b0);
        drive(Y, 1'b0);
        check("red_lost_fault", obs & 8'b1101_1111, 8'b0100_0001);

        // Conflicting lamps while idle.
        do_reset();
        drive(RG, 1'b0);
        check("idle_conflict", obs & 8'b1101_1111, 8'b0100_0001);

        // Asynchronous reset in the middle of clearance with a request pending.
        do_reset();
        drive(Y, 1'b0);
        drive(R, 1'b1);
        drive(R, 1'b1);
        drive(R, 1'b0);
        drive(R, 1'b0);
        check("pre_reset_clear", obs, o(0, 1, 1, 1, 2));
        #2 reset_n = 1'b0;
        #1 check("async_reset", obs, o(0, 1, 0, 0, 0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(G, 1'b0);
        check("post_reset_idle", obs, o(0, 1, 0, 0, 0));

        // Randomized legal traffic with random presses.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            int g, y, r;
            g = $urandom_range(2, 6);
            y = $urandom_range(1, 2);
            r = $urandom_range(6, 8);
            for (int j = 0; j < g; j++) seq.push_back(G);
            for (int j = 0; j < y; j++) seq.push_back(Y);
            for (int j = 0; j < r; j++) seq.push_back(R);
        end
        m_n = 0;
        m_svc = -1;
        m_pend = 1'b0;
        m_prev_red = 1'b0;
        foreach (seq[i]) begin
            logic b;
            b = ($urandom_range(0, 3) == 0);
            model_step(seq[i][2], b);
            drive(seq[i], b);
            check($sformatf("rand%0d", i), obs, model_exp());
            check($sformatf("rand_excl%0d", i), {6'b0, walk, dont_walk}, {6'b0, walk, ~walk});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ped_signal_ctrl.md
PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

Interface
REQ-001 Parameter WALK_TIME, default 3, SHALL set the number of cycles walk is asserted per service (range 1..4).
REQ-002 Parameter CLEAR_TIME, default 2, SHALL set the number of flashing don't-walk cycles per service (range 1..4).
REQ-003 Elaboration SHALL fail when WALK_TIME + CLEAR_TIME > 5, which is the largest window that fits the 6-cycle vehicle red phase.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on clk.
REQ-006 veh_red  input  1  vehicle red lamp from upstream traffic_light.
REQ-007 veh_yellow  input  1  vehicle yellow lamp from upstream traffic_light.
REQ-008 veh_green  input  1  vehicle green lamp from upstream traffic_light.
REQ-009 ped_button  input  1  pedestrian request, synchronous to clk, level-sensitive.
REQ-010 walk  output  1  walk lamp.
REQ-011 dont_walk  output  1  don't-walk lamp (steady or flashing).
REQ-012 flash  output  1  flash phase of dont_walk during clearance.
REQ-013 req_pending  output  1  an unserved request is latched.
REQ-014 countdown  output  3  remaining cycles of the current WALK or CLEAR phase, including the current cycle; 0 otherwise.
REQ-015 error  output  1  sticky conflict/fault flag.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT, WALK, CLEAR and FAULT; all outputs SHALL be registered or decoded from registered state only.
REQ-017 A vehicle red rising edge SHALL be the cycle in which veh_red=1 and the registered copy veh_red_d=0.
REQ-018 IDLE: dont_walk=1, walk=0, flash=0. ped_button=1 SHALL move the FSM to WAIT and set req_pending.
REQ-019 WAIT: a red rising edge SHALL move the FSM to WALK on the next edge and clear req_pending; a request made while red is already on SHALL wait for the next red rising edge.
REQ-020 When ped_button=1 in IDLE in the same cycle as a red rising edge, the FSM SHALL go directly to WALK and req_pending SHALL stay 0.
REQ-021 WALK: walk=1 and dont_walk=0 for exactly WALK_TIME cycles; countdown SHALL run WALK_TIME down to 1; then the FSM SHALL enter CLEAR.
REQ-022 CLEAR: walk=0, dont_walk=1, for exactly CLEAR_TIME cycles; flash SHALL be 1 in the first cycle and toggle every cycle; countdown SHALL run CLEAR_TIME down to 1.
REQ-023 On CLEAR exit, the FSM SHALL go to WAIT if req_pending=1, otherwise to IDLE.
REQ-024 ped_button during WALK or CLEAR SHALL set req_pending; that request SHALL be served at the next red rising edge, not the current red phase.
REQ-025 Latency: walk SHALL rise exactly 1 cycle after the cycle in which the red rising edge is observed.
REQ-026 In WALK or CLEAR, veh_red=0 SHALL force FAULT on the next edge.
REQ-027 In any state, vehicle inputs not exactly one-hot SHALL force FAULT on the next edge.
REQ-028 FAULT: walk=0, dont_walk=1, flash toggles every cycle, error=1, countdown=0, req_pending=0; FAULT SHALL be exited only by reset.
REQ-029 walk and dont_walk SHALL never be 1 simultaneously, and SHALL never both be 0.

Reset
REQ-030 While reset_n=0: state=IDLE, veh_red_d=0, walk=0, dont_walk=1, flash=0, req_pending=0, countdown=0, error=0.
REQ-031 Reset asserted mid-WALK or mid-CLEAR SHALL drop walk and restore don't-walk immediately (asynchronous), and SHALL discard any pending request.

Structure
REQ-032 Package ped_pkg SHALL hold the 3-bit state encoding (IDLE=000, WAIT=001, WALK=010, CLEAR=011, FAULT=100) and the default WALK_TIME and CLEAR_TIME constants.
REQ-033 One sub-module, rise_detect, SHALL register veh_red and output the 1-cycle rising-edge pulse; the rest is a single module.

Verification
REQ-034 Chained with traffic_light: ped_button pulse in GREEN -> at the next RED onset (cycle t) walk=1 for t+1..t+3 with countdown 3,2,1; CLEAR for t+4..t+5 with flash 1,0 and countdown 2,1; IDLE at t+6; walk never overlaps veh_green.
REQ-035 ped_button in the same cycle as the red rising edge -> walk at the next cycle, req_pending never set.
REQ-036 ped_button during WALK -> req_pending=1 through the rest of the service, FSM goes CLEAR->WAIT, served at the next red onset.
REQ-037 veh_green forced to 1 during WALK (countdown=2) -> next cycle FAULT: error=1, walk=0, flash toggling; stays until reset_n=0.
REQ-038 veh_red=veh_green=1 while IDLE -> FAULT next cycle; reset_n pulsed low mid-CLEAR -> all outputs at reset values immediately, IDLE after release.
